// File: rtl/enemy_field.sv
// enemy_field: falling enemy with bullet/player collisions, lives and score; ENEMY_SPEEDUP_EN adds score-based fall speed-up
module enemy_field #(
  parameter int E_SIZE     = 16,
  parameter int D_WIDTH    = 640,
  parameter int D_HEIGHT   = 480,
  parameter int SPEED      = 2,
  parameter int LIVES      = 3,
  parameter int HIT_FRAMES = 16
)(
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_ani_stb,
  input  logic        i_animate,
  input  logic        i_paused,
  input  logic        i_firing,
  input  logic [11:0] i_bx1,
  input  logic [11:0] i_bx2,
  input  logic [11:0] i_by1,
  input  logic [11:0] i_by2,
  input  logic [11:0] i_px1,
  input  logic [11:0] i_px2,
  input  logic [11:0] i_py1,
  input  logic [11:0] i_py2,
  output logic [11:0] o_ex1,
  output logic [11:0] o_ex2,
  output logic [11:0] o_ey1,
  output logic [11:0] o_ey2,
  output logic        o_hit,
  output logic        o_ouch,
  output logic        o_exploding,
  output logic        o_game_over,
  output logic [7:0]  o_score,
  output logic [1:0]  o_lives
);
  localparam int CW = $clog2(HIT_FRAMES + 1);
  if (E_SIZE + 511 > D_WIDTH - E_SIZE) begin : g_bad_size
    $error("enemy spawn range exceeds display width");
  end
  typedef enum logic [1:0] {SPAWN, FALL, HIT, OVER} state_t;
  state_t state, state_n;
  logic [11:0] ex, ey, ex_n, ey_n, step;
  logic [7:0] score, score_n;
  logic [1:0] lives, lives_n, lives_dec;
  logic [CW-1:0] cnt, cnt_n;
  logic [9:0] lfsr;
  logic hit_n, ouch_n, tick, p_ov, b_ov, bottom, last;
  assign tick = i_animate & i_ani_stb & ~i_paused;
  assign o_ex1 = ex - 12'(E_SIZE);
  assign o_ex2 = ex + 12'(E_SIZE);
  assign o_ey1 = ey - 12'(E_SIZE);
  assign o_ey2 = ey + 12'(E_SIZE);
  assign p_ov = (o_ex1 < i_px2) & (i_px1 < o_ex2) & (o_ey1 < i_py2) & (i_py1 < o_ey2);
  assign b_ov = i_firing & (o_ex1 < i_bx2) & (i_bx1 < o_ex2) & (o_ey1 < i_by2) & (i_by1 < o_ey2);
`ifdef ENEMY_SPEEDUP_EN
  assign step = 12'(SPEED) + (score[7:3] > 5'd3 ? 12'd3 : 12'(score[7:3]));
`else
  assign step = 12'(SPEED);
`endif
  assign bottom = ey + 12'(E_SIZE) + step >= 12'(D_HEIGHT);
  assign lives_dec = lives == 2'd0 ? 2'd0 : lives - 2'd1;
  assign last = cnt == CW'(HIT_FRAMES - 1);
  assign o_score = score;
  assign o_lives = lives;
  assign o_exploding = state == HIT;
  assign o_game_over = state == OVER;
  // next state, position and counters; everything holds unless a tick arrives
  always_comb begin
    state_n = state;
    ex_n = ex;
    ey_n = ey;
    score_n = score;
    lives_n = lives;
    cnt_n = cnt;
    hit_n = 1'b0;
    ouch_n = 1'b0;
    if (tick)
      case (state)
        SPAWN: begin
          ex_n = 12'(E_SIZE) + 12'(lfsr[8:0]);
          ey_n = 12'(E_SIZE);
          state_n = FALL;
        end
        FALL: begin
          if (p_ov) begin
            lives_n = lives_dec;
            ouch_n = 1'b1;
            state_n = HIT;
          end else if (b_ov) begin
            score_n = score == 8'hFF ? score : score + 8'd1;
            hit_n = 1'b1;
            state_n = HIT;
          end else if (bottom) begin
            lives_n = lives_dec;
            ouch_n = 1'b1;
            state_n = lives_dec == 2'd0 ? OVER : SPAWN;
          end else
            ey_n = ey + step;
        end
        HIT: begin
          cnt_n = last ? '0 : cnt + CW'(1);
          if (last) state_n = lives == 2'd0 ? OVER : SPAWN;
        end
        default: ;
      endcase
  end
  // state and datapath registers; the LFSR free-runs every clock
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= SPAWN;
      ex <= 12'(D_WIDTH / 2);
      ey <= 12'(E_SIZE);
      score <= '0;
      lives <= 2'(LIVES);
      cnt <= '0;
      lfsr <= 10'h1A5;
      o_hit <= 1'b0;
      o_ouch <= 1'b0;
    end else begin
      state <= state_n;
      ex <= ex_n;
      ey <= ey_n;
      score <= score_n;
      lives <= lives_n;
      cnt <= cnt_n;
      lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      o_hit <= hit_n;
      o_ouch <= ouch_n;
    end
  end
endmodule
